// File: rtl/countdown_timer_if.sv
// Countdown timer control/status bundle: one-cycle command pulses and the
// ms timebase strobe in, registered time/state out.
interface countdown_timer_if;
    logic       i_set;
    logic       i_up;
    logic       i_down;
    logic       i_left;
    logic       i_right;
    logic       i_ms_pulse;
    logic [5:0] o_sec;
    logic [5:0] o_min;
    logic [4:0] o_hr;
    logic [1:0] o_field;
    logic       o_running;
    logic       o_alarm;

    // Stimulus side: drives the pulses, observes the timer.
    modport master (
        output i_set, i_up, i_down, i_left, i_right, i_ms_pulse,
        input  o_sec, o_min, o_hr, o_field, o_running, o_alarm
    );

    // Timer side.
    modport slave (
        input  i_set, i_up, i_down, i_left, i_right, i_ms_pulse,
        output o_sec, o_min, o_hr, o_field, o_running, o_alarm
    );
endinterface

// File: rtl/countdown_timer.sv
// Countdown timer: hh:mm:ss editable with a field cursor, counts down on a
// 1 ms strobe, supports pause/resume and raises an alarm at 00:00:00.
// Optional feature macro: TIMER_ALARM_AUTOCLEAR_EN -- when defined the alarm
// drops back to EDIT on its own after ALARM_MS strobes.
module countdown_timer #(
    parameter int unsigned MS_PER_SEC = 1000,
    parameter int unsigned ALARM_MS   = 5000
) (
    input logic               i_clk,
    input logic               i_rstn,
    countdown_timer_if.slave  bus
);

    localparam logic [1:0] ST_EDIT  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_ALARM = 2'd3;

    localparam logic [1:0] FLD_SEC = 2'd0;
    localparam logic [1:0] FLD_MIN = 2'd1;
    localparam logic [1:0] FLD_HR  = 2'd2;

    localparam int unsigned MsW = (MS_PER_SEC > 1) ? $clog2(MS_PER_SEC) : 1;
    localparam logic [MsW-1:0] MsReload = MsW'(MS_PER_SEC - 1);
    localparam logic [MsW-1:0] MsOne    = MsW'(1);

    // Reject degenerate configurations at elaboration.
    if (MS_PER_SEC < 1 || ALARM_MS < 1) begin : g_param_check
        $error("countdown_timer: MS_PER_SEC and ALARM_MS must be at least 1");
    end

    logic [1:0]     state_q, state_d;
    logic [5:0]     sec_q, sec_d;
    logic [5:0]     min_q, min_d;
    logic [4:0]     hr_q, hr_d;
    logic [1:0]     field_q, field_d;
    logic [MsW-1:0] ms_q, ms_d;
    logic           running_q, running_d;
    logic           alarm_q, alarm_d;

`ifdef TIMER_ALARM_AUTOCLEAR_EN
    localparam int unsigned AlmW = (ALARM_MS > 1) ? $clog2(ALARM_MS) : 1;
    localparam logic [AlmW-1:0] AlmLast = AlmW'(ALARM_MS - 1);
    localparam logic [AlmW-1:0] AlmOne  = AlmW'(1);

    logic [AlmW-1:0] alm_cnt_q, alm_cnt_d;
`endif

    // Decoded single-cycle commands; opposing pairs cancel each other.
    logic cmd_left, cmd_right, cmd_up, cmd_down;
    assign cmd_left  = bus.i_left  & ~bus.i_right;
    assign cmd_right = bus.i_right & ~bus.i_left;
    assign cmd_up    = bus.i_up    & ~bus.i_down;
    assign cmd_down  = bus.i_down  & ~bus.i_up;

    logic time_nonzero;
    assign time_nonzero = (sec_q != 6'd0) || (min_q != 6'd0) || (hr_q != 5'd0);

    // One-second decrement with borrow chain; saturates at zero.
    logic [5:0] dec_sec, dec_min;
    logic [4:0] dec_hr;
    logic       dec_zero;
    always_comb begin
        dec_sec = sec_q;
        dec_min = min_q;
        dec_hr  = hr_q;
        if (sec_q != 6'd0) begin
            dec_sec = sec_q - 6'd1;
        end else if (min_q != 6'd0) begin
            dec_sec = 6'd59;
            dec_min = min_q - 6'd1;
        end else if (hr_q != 5'd0) begin
            dec_sec = 6'd59;
            dec_min = 6'd59;
            dec_hr  = hr_q - 5'd1;
        end
        dec_zero = (dec_sec == 6'd0) && (dec_min == 6'd0) && (dec_hr == 5'd0);
    end

    // Next-state logic for the FSM, time fields, cursor and subcounters.
    always_comb begin
        state_d = state_q;
        sec_d   = sec_q;
        min_d   = min_q;
        hr_d    = hr_q;
        field_d = field_q;
        ms_d    = ms_q;
`ifdef TIMER_ALARM_AUTOCLEAR_EN
        alm_cnt_d = alm_cnt_q;
`endif

        case (state_q)
            ST_EDIT: begin
                if (bus.i_set) begin
                    // A zero time is not startable; the press is consumed.
                    if (time_nonzero) begin
                        ms_d    = MsReload;
                        state_d = ST_RUN;
                    end
                end else if (cmd_left) begin
                    field_d = (field_q == FLD_HR) ? FLD_SEC : field_q + 2'd1;
                end else if (cmd_right) begin
                    field_d = (field_q == FLD_SEC) ? FLD_HR : field_q - 2'd1;
                end else if (cmd_up) begin
                    case (field_q)
                        FLD_SEC: sec_d = (sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1;
                        FLD_MIN: min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
                        FLD_HR:  hr_d  = (hr_q == 5'd23) ? 5'd0 : hr_q + 5'd1;
                        default: ;
                    endcase
                end else if (cmd_down) begin
                    case (field_q)
                        FLD_SEC: sec_d = (sec_q == 6'd0) ? 6'd59 : sec_q - 6'd1;
                        FLD_MIN: min_d = (min_q == 6'd0) ? 6'd59 : min_q - 6'd1;
                        FLD_HR:  hr_d  = (hr_q == 5'd0) ? 5'd23 : hr_q - 5'd1;
                        default: ;
                    endcase
                end
            end

            ST_RUN: begin
                // Strobe is applied before i_set so a same-cycle pause
                // still sees the decrement, and reaching zero wins.
                if (bus.i_ms_pulse) begin
                    if (ms_q == '0) begin
                        ms_d  = MsReload;
                        sec_d = dec_sec;
                        min_d = dec_min;
                        hr_d  = dec_hr;
                        if (dec_zero) begin
                            state_d = ST_ALARM;
`ifdef TIMER_ALARM_AUTOCLEAR_EN
                            alm_cnt_d = '0;
`endif
                        end
                    end else begin
                        ms_d = ms_q - MsOne;
                    end
                end
                if (bus.i_set && state_d != ST_ALARM) begin
                    state_d = ST_PAUSE;
                end
            end

            ST_PAUSE: begin
                // Resume keeps the partially elapsed second.
                if (bus.i_set) begin
                    state_d = ST_RUN;
                end else if (cmd_left) begin
                    state_d = ST_EDIT;
                end
            end

            ST_ALARM: begin
                if (bus.i_set) begin
                    state_d = ST_EDIT;
                    field_d = FLD_SEC;
`ifdef TIMER_ALARM_AUTOCLEAR_EN
                    alm_cnt_d = '0;
                end else if (bus.i_ms_pulse) begin
                    if (alm_cnt_q == AlmLast) begin
                        state_d   = ST_EDIT;
                        field_d   = FLD_SEC;
                        alm_cnt_d = '0;
                    end else begin
                        alm_cnt_d = alm_cnt_q + AlmOne;
                    end
`endif
                end
            end

            default: begin
                state_d = ST_EDIT;
                field_d = FLD_SEC;
            end
        endcase

        running_d = (state_d == ST_RUN);
        alarm_d   = (state_d == ST_ALARM);
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q   <= ST_EDIT;
            sec_q     <= '0;
            min_q     <= '0;
            hr_q      <= '0;
            field_q   <= FLD_SEC;
            ms_q      <= '0;
            running_q <= 1'b0;
            alarm_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            sec_q     <= sec_d;
            min_q     <= min_d;
            hr_q      <= hr_d;
            field_q   <= field_d;
            ms_q      <= ms_d;
            running_q <= running_d;
            alarm_q   <= alarm_d;
        end
    end

`ifdef TIMER_ALARM_AUTOCLEAR_EN
    // Alarm duration counter, present only with auto-clear.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            alm_cnt_q <= '0;
        end else begin
            alm_cnt_q <= alm_cnt_d;
        end
    end
`endif

    // Outputs come straight from registers.
    always_comb begin
        bus.o_sec     = sec_q;
        bus.o_min     = min_q;
        bus.o_hr      = hr_q;
        bus.o_field   = field_q;
        bus.o_running = running_q;
        bus.o_alarm   = alarm_q;
    end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer (MS_PER_SEC=4, ALARM_MS=8).
module tb_countdown_timer;

    localparam logic [5:0] K_SET = 6'b100000;
    localparam logic [5:0] K_UP  = 6'b010000;
    localparam logic [5:0] K_DN  = 6'b001000;
    localparam logic [5:0] K_LT  = 6'b000100;
    localparam logic [5:0] K_RT  = 6'b000010;
    localparam logic [5:0] K_MS  = 6'b000001;

    logic clk;
    logic rstn;
    int   checks;
    int   failures;

    countdown_timer_if bus ();

    countdown_timer #(
        .MS_PER_SEC (4),
        .ALARM_MS   (8)
    ) dut (
        .i_clk  (clk),
        .i_rstn (rstn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one pulse vector for a single cycle, starting at a falling edge.
    task automatic step(input logic [5:0] v);
        {bus.i_set, bus.i_up, bus.i_down, bus.i_left, bus.i_right, bus.i_ms_pulse} = v;
        @(negedge clk);
        {bus.i_set, bus.i_up, bus.i_down, bus.i_left, bus.i_right, bus.i_ms_pulse} = '0;
    endtask

    task automatic ms(input int n);
        for (int i = 0; i < n; i++) step(K_MS);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    // Reset, then load h:m:s with up presses; leaves the cursor on seconds.
    task automatic set_time(input int h, input int m, input int s);
        do_reset();
        for (int i = 0; i < s; i++) step(K_UP);
        step(K_LT);
        for (int i = 0; i < m; i++) step(K_UP);
        step(K_LT);
        for (int i = 0; i < h; i++) step(K_UP);
        step(K_LT);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({bus.o_hr, bus.o_min, bus.o_sec} !== 17'd0) begin
            failures++;
            $display("FAIL reset_time got=%0d:%0d:%0d exp=0:0:0", bus.o_hr, bus.o_min, bus.o_sec);
        end
        checks++;
        if ({bus.o_field, bus.o_running, bus.o_alarm} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags got field=%0d run=%b alarm=%b exp 0/0/0",
                     bus.o_field, bus.o_running, bus.o_alarm);
        end
    endtask

    task automatic test_edit();
        do_reset();
        step(K_LT);
        step(K_UP);
        step(K_UP);
        checks++;
        if (bus.o_min !== 6'd2 || bus.o_field !== 2'd1) begin
            failures++;
            $display("FAIL edit_min_up got min=%0d field=%0d exp min=2 field=1", bus.o_min, bus.o_field);
        end
        repeat (3) step(K_DN);
        checks++;
        if (bus.o_min !== 6'd59 || bus.o_sec !== 6'd0 || bus.o_hr !== 5'd0) begin
            failures++;
            $display("FAIL edit_min_wrap got=%0d:%0d:%0d exp=0:59:0", bus.o_hr, bus.o_min, bus.o_sec);
        end
        step(K_RT);
        step(K_RT);
        checks++;
        if (bus.o_field !== 2'd2) begin
            failures++;
            $display("FAIL edit_cursor_right got=%0d exp=2", bus.o_field);
        end
        step(K_DN);
        checks++;
        if (bus.o_hr !== 5'd23 || bus.o_min !== 6'd59) begin
            failures++;
            $display("FAIL edit_hr_wrap got hr=%0d min=%0d exp hr=23 min=59", bus.o_hr, bus.o_min);
        end
        step(K_LT);
        step(K_UP);
        checks++;
        if (bus.o_field !== 2'd0 || bus.o_sec !== 6'd1) begin
            failures++;
            $display("FAIL edit_cursor_wrap got field=%0d sec=%0d exp field=0 sec=1",
                     bus.o_field, bus.o_sec);
        end
    endtask

    task automatic test_priority();
        do_reset();
        step(K_UP | K_DN);
        checks++;
        if (bus.o_sec !== 6'd0) begin
            failures++;
            $display("FAIL prio_updown got sec=%0d exp=0", bus.o_sec);
        end
        step(K_LT | K_RT);
        checks++;
        if (bus.o_field !== 2'd0) begin
            failures++;
            $display("FAIL prio_leftright got field=%0d exp=0", bus.o_field);
        end
        step(K_LT | K_UP);
        checks++;
        if (bus.o_field !== 2'd1 || bus.o_sec !== 6'd0 || bus.o_min !== 6'd0) begin
            failures++;
            $display("FAIL prio_left_over_up got field=%0d sec=%0d min=%0d exp 1/0/0",
                     bus.o_field, bus.o_sec, bus.o_min);
        end
        step(K_SET | K_LT | K_UP);
        checks++;
        if (bus.o_field !== 2'd1 || bus.o_running !== 1'b0 || bus.o_min !== 6'd0) begin
            failures++;
            $display("FAIL prio_set_zero got field=%0d run=%b min=%0d exp 1/0/0",
                     bus.o_field, bus.o_running, bus.o_min);
        end
    endtask

    task automatic test_run();
        set_time(0, 1, 0);
        step(K_SET);
        checks++;
        if (bus.o_running !== 1'b1 || bus.o_min !== 6'd1 || bus.o_sec !== 6'd0) begin
            failures++;
            $display("FAIL run_start got run=%b min=%0d sec=%0d exp 1/1/0",
                     bus.o_running, bus.o_min, bus.o_sec);
        end
        step(K_UP);
        ms(3);
        checks++;
        if (bus.o_min !== 6'd1 || bus.o_sec !== 6'd0) begin
            failures++;
            $display("FAIL run_3ms got=%0d:%0d exp=1:0", bus.o_min, bus.o_sec);
        end
        bus.i_ms_pulse = 1'b1;
        #1;
        checks++;
        if (bus.o_sec !== 6'd0) begin
            failures++;
            $display("FAIL run_latency got sec=%0d exp=0 before edge", bus.o_sec);
        end
        @(negedge clk);
        bus.i_ms_pulse = 1'b0;
        checks++;
        if (bus.o_sec !== 6'd59 || bus.o_min !== 6'd0 || bus.o_running !== 1'b1) begin
            failures++;
            $display("FAIL run_borrow_min got min=%0d sec=%0d run=%b exp 0/59/1",
                     bus.o_min, bus.o_sec, bus.o_running);
        end
        set_time(1, 0, 0);
        step(K_SET);
        ms(4);
        checks++;
        if ({bus.o_hr, bus.o_min, bus.o_sec} !== {5'd0, 6'd59, 6'd59}) begin
            failures++;
            $display("FAIL run_borrow_hr got=%0d:%0d:%0d exp=0:59:59", bus.o_hr, bus.o_min, bus.o_sec);
        end
    endtask

    task automatic test_alarm();
        set_time(0, 0, 1);
        step(K_LT);
        step(K_SET);
        ms(4);
        checks++;
        if (bus.o_alarm !== 1'b1 || bus.o_running !== 1'b0 || bus.o_sec !== 6'd0) begin
            failures++;
            $display("FAIL alarm_enter got alarm=%b run=%b sec=%0d exp 1/0/0",
                     bus.o_alarm, bus.o_running, bus.o_sec);
        end
        ms(7);
        checks++;
        if (bus.o_alarm !== 1'b1) begin
            failures++;
            $display("FAIL alarm_hold7 got=%b exp=1", bus.o_alarm);
        end
        ms(1);
`ifdef TIMER_ALARM_AUTOCLEAR_EN
        checks++;
        if (bus.o_alarm !== 1'b0 || bus.o_field !== 2'd0) begin
            failures++;
            $display("FAIL alarm_autoclear got alarm=%b field=%0d exp 0/0", bus.o_alarm, bus.o_field);
        end
`else
        checks++;
        if (bus.o_alarm !== 1'b1 || bus.o_field !== 2'd1) begin
            failures++;
            $display("FAIL alarm_persist got alarm=%b field=%0d exp 1/1", bus.o_alarm, bus.o_field);
        end
`endif
        ms(12);
        checks++;
        if ({bus.o_hr, bus.o_min, bus.o_sec} !== 17'd0 || bus.o_running !== 1'b0) begin
            failures++;
            $display("FAIL alarm_no_wrap got=%0d:%0d:%0d run=%b exp=0:0:0 run=0",
                     bus.o_hr, bus.o_min, bus.o_sec, bus.o_running);
        end
        step(K_SET);
        checks++;
        if (bus.o_alarm !== 1'b0 || bus.o_field !== 2'd0 || bus.o_running !== 1'b0) begin
            failures++;
            $display("FAIL alarm_set_exit got alarm=%b field=%0d run=%b exp 0/0/0",
                     bus.o_alarm, bus.o_field, bus.o_running);
        end
        // Early acknowledge after only a few strobes.
        set_time(0, 0, 1);
        step(K_LT);
        step(K_SET);
        ms(7);
        step(K_SET);
        checks++;
        if (bus.o_alarm !== 1'b0 || bus.o_field !== 2'd0) begin
            failures++;
            $display("FAIL alarm_early_set got alarm=%b field=%0d exp 0/0", bus.o_alarm, bus.o_field);
        end
    endtask

    task automatic test_pause();
        set_time(0, 0, 5);
        step(K_SET);
        ms(2);
        step(K_SET);
        checks++;
        if (bus.o_running !== 1'b0 || bus.o_alarm !== 1'b0) begin
            failures++;
            $display("FAIL pause_enter got run=%b alarm=%b exp 0/0", bus.o_running, bus.o_alarm);
        end
        ms(10);
        step(K_UP);
        checks++;
        if (bus.o_sec !== 6'd5) begin
            failures++;
            $display("FAIL pause_hold got sec=%0d exp=5", bus.o_sec);
        end
        step(K_SET);
        checks++;
        if (bus.o_running !== 1'b1) begin
            failures++;
            $display("FAIL pause_resume got run=%b exp=1", bus.o_running);
        end
        ms(1);
        checks++;
        if (bus.o_sec !== 6'd5) begin
            failures++;
            $display("FAIL pause_sub_kept1 got sec=%0d exp=5", bus.o_sec);
        end
        ms(1);
        checks++;
        if (bus.o_sec !== 6'd4) begin
            failures++;
            $display("FAIL pause_sub_kept2 got sec=%0d exp=4", bus.o_sec);
        end
        step(K_SET);
        step(K_LT);
        step(K_UP);
        checks++;
        if (bus.o_sec !== 6'd5 || bus.o_running !== 1'b0) begin
            failures++;
            $display("FAIL pause_to_edit got sec=%0d run=%b exp 5/0", bus.o_sec, bus.o_running);
        end
    endtask

    task automatic test_same_cycle();
        set_time(0, 0, 2);
        step(K_SET);
        ms(3);
        step(K_SET | K_MS);
        checks++;
        if (bus.o_sec !== 6'd1 || bus.o_running !== 1'b0 || bus.o_alarm !== 1'b0) begin
            failures++;
            $display("FAIL same_cycle_pause got sec=%0d run=%b alarm=%b exp 1/0/0",
                     bus.o_sec, bus.o_running, bus.o_alarm);
        end
        step(K_SET);
        ms(3);
        step(K_SET | K_MS);
        checks++;
        if (bus.o_sec !== 6'd0 || bus.o_alarm !== 1'b1 || bus.o_running !== 1'b0) begin
            failures++;
            $display("FAIL same_cycle_alarm got sec=%0d alarm=%b run=%b exp 0/1/0",
                     bus.o_sec, bus.o_alarm, bus.o_running);
        end
    endtask

    task automatic test_async_reset();
        set_time(0, 2, 3);
        step(K_SET);
        ms(2);
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if ({bus.o_hr, bus.o_min, bus.o_sec, bus.o_field, bus.o_running, bus.o_alarm} !== 21'd0) begin
            failures++;
            $display("FAIL async_reset got=%0d:%0d:%0d field=%0d run=%b alarm=%b exp all 0",
                     bus.o_hr, bus.o_min, bus.o_sec, bus.o_field, bus.o_running, bus.o_alarm);
        end
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        step(K_UP);
        checks++;
        if (bus.o_sec !== 6'd1 || bus.o_running !== 1'b0) begin
            failures++;
            $display("FAIL reset_resume got sec=%0d run=%b exp 1/0", bus.o_sec, bus.o_running);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rstn     = 1'b0;
        {bus.i_set, bus.i_up, bus.i_down, bus.i_left, bus.i_right, bus.i_ms_pulse} = '0;
        test_reset();
        test_edit();
        test_priority();
        test_run();
        test_alarm();
        test_pause();
        test_same_cycle();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
